uart_tx_sched: RTL and testbench

//  Shares the write port of one UART TX fifo (WIDTH/NCBIT fifo) among NREQ requesters

---
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART TX fifo write port among NREQ
// requesters, plus a drain FSM that pops one word per transmitter frame.
module uart_tx_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   parameter int CNTW  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*WIDTH-1:0]  req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [WIDTH-1:0]       fifo_wdata,
   output logic                   fifo_wr_en,
   input  logic                   fifo_full,
   output logic                   fifo_rd_en,
   input  logic [WIDTH-1:0]       fifo_rdata,
   input  logic                   fifo_empty,
   output logic [WIDTH-1:0]       tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [CNTW-1:0]        tx_count
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_WAITB,
      S_WAITD
   } state_t;

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_next;
   logic [PW-1:0]    cand;
   logic [PW-1:0]    idx;
   logic             found;
   logic             grant;

   state_t           state;
   state_t           state_next;
   logic             wait_cnt;
   logic             wait_next;
   logic             rd_next;
   logic             start_next;
   logic [WIDTH-1:0] data_next;
   logic [CNTW-1:0]  count_next;

   // Find the first valid requester at or after the round-robin pointer.
   always_comb begin
      cand  = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            cand  = idx;
            found = 1'b1;
         end
      end
   end

   // Grant the candidate only when enabled, out of reset and the fifo has room.
   always_comb begin
      grant      = found & en & ~fifo_full & ~rst;
      req_ready  = '0;
      fifo_wdata = '0;
      if (grant) begin
         req_ready[cand] = 1'b1;
         fifo_wdata      = req_data[int'(cand)*WIDTH +: WIDTH];
      end
      fifo_wr_en = |(req_valid & req_ready);
      ptr_next   = ptr;
      if (fifo_wr_en) begin
         ptr_next = (cand == LAST) ? '0 : cand + PW'(1);
      end
   end

   // Round-robin pointer advances past the requester that just transferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

   // Drain sequencing: pop, wait for fifo data, launch a frame, then track busy.
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      rd_next    = 1'b0;
      start_next = 1'b0;
      data_next  = tx_data;
      count_next = tx_count;
      case (state)
         S_IDLE: begin
            if (en && !fifo_empty && !tx_busy) begin
               rd_next    = 1'b1;
               state_next = S_POP;
            end
         end
         S_POP: begin
            state_next = S_LOAD;
         end
         S_LOAD: begin
            data_next  = fifo_rdata;
            start_next = 1'b1;
            count_next = tx_count + CNTW'(1);
            wait_next  = 1'b0;
            state_next = S_WAITB;
         end
         S_WAITB: begin
            if (tx_busy || wait_cnt) begin
               state_next = S_WAITD;
            end else begin
               wait_next = 1'b1;
            end
         end
         S_WAITD: begin
            if (!tx_busy) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Drain state and its registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= 1'b0;
         fifo_rd_en <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         tx_count   <= '0;
      end else begin
         state      <= state_next;
         wait_cnt   <= wait_next;
         fifo_rd_en <= rd_next;
         tx_start   <= start_next;
         tx_data    <= data_next;
         tx_count   <= count_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: drives uart_tx_sched against a behavioural fifo and
// transmitter, with a table of arbiter vectors, directed corner sequences and
// a randomized phase checked against a round-robin reference model.
module tb_uart_tx_sched;

   localparam int WIDTH = 8;
   localparam int NREQ  = 3;
   localparam int CNTW  = 4;
   localparam int DEPTH = 128;
   localparam int DW    = NREQ * WIDTH;
   localparam logic [DW-1:0] RRD = {8'hC2, 8'hB1, 8'hA0};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [NREQ-1:0]  req_valid = '0;
   logic [DW-1:0]    req_data = '0;
   logic [NREQ-1:0]  req_ready;
   logic [WIDTH-1:0] fifo_wdata;
   logic             fifo_wr_en;
   logic             fifo_full;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rdata = '0;
   logic             fifo_empty;
   logic [WIDTH-1:0] tx_data;
   logic             tx_start;
   logic             tx_busy;
   logic [CNTW-1:0]  tx_count;

   int   fifo_cnt = 0;
   int   busy_cnt = 0;
   int   busy_len = 10;
   int   cyc = 0;
   logic full_force = 1'b0;
   logic busy_force = 1'b0;
   logic preload_req = 1'b0;
   logic prev_rd = 1'b0;
   int   overflow_n = 0;
   int   underflow_n = 0;
   int   b2b_n = 0;
   int   hold_n = 0;

   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] sent_q[$];
   int               start_q[$];
   logic [WIDTH-1:0] exp_q[$];

   int nvec = 0;
   int nerr = 0;
   int base = 0;

   typedef struct {
      logic            e;
      logic            f;
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] rdy;
      logic            wr;
      logic [WIDTH-1:0] wd;
   } vec_t;
   vec_t tbl[13];

   uart_tx_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_wdata (fifo_wdata),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .fifo_empty (fifo_empty),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_count   (tx_count)
   );

   assign fifo_full  = (fifo_cnt >= DEPTH) || full_force;
   assign fifo_empty = (fifo_cnt == 0);
   assign tx_busy    = (busy_cnt != 0) || busy_force;

   always #5 clk = ~clk;

   // Free-running cycle counter used to time frame starts.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural fifo: flushed by rst, data valid the cycle after rd_en.
   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         fifo_cnt <= 0;
      end else begin
         if (preload_req) begin
            while (fq.size() < DEPTH) fq.push_back(WIDTH'(fq.size()) ^ 8'h3C);
         end
         if (fifo_rd_en) begin
            if (fq.size() == 0) underflow_n <= underflow_n + 1;
            else fifo_rdata <= fq.pop_front();
         end
         if (fifo_wr_en) begin
            if (fifo_full) overflow_n <= overflow_n + 1;
            else fq.push_back(fifo_wdata);
         end
         fifo_cnt <= fq.size();
      end
   end

   // Behavioural transmitter: busy for busy_len cycles after each start pulse.
   always @(posedge clk) begin
      prev_rd <= fifo_rd_en;
      if (fifo_rd_en && prev_rd) b2b_n <= b2b_n + 1;
      if (rst) begin
         busy_cnt <= 0;
      end else if (tx_start) begin
         busy_cnt <= busy_len;
         sent_q.push_back(tx_data);
         start_q.push_back(cyc);
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (sent_q.size() > 0 && tx_data != sent_q[$]) hold_n <= hold_n + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [NREQ-1:0] v, input logic [DW-1:0] d, input logic f);
      @(negedge clk);
      en = e;
      req_valid = v;
      req_data = d;
      full_force = f;
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      full_force = 1'b0;
      busy_force = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      #1;
      base = sent_q.size();
   endtask

   task automatic wait_sent(input int n, input int budget, input string name);
      int k = 0;
      while ((sent_q.size() - base) < n && k < budget) begin
         step();
         k++;
      end
      checkOutput(name, sent_q.size() - base, n);
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rdn;
      int k;
      logic            e;
      logic            f;
      logic [NREQ-1:0] v;
      logic [DW-1:0]   d;
      logic [NREQ-1:0] er;
      logic            ew;
      logic [WIDTH-1:0] ewd;
      int              mptr;
      int              mcand;

      tbl[0]  = '{1'b1, 1'b0, 3'b011, 3'b001, 1'b1, 8'hA0};
      tbl[1]  = '{1'b1, 1'b0, 3'b011, 3'b010, 1'b1, 8'hB1};
      tbl[2]  = '{1'b1, 1'b0, 3'b011, 3'b001, 1'b1, 8'hA0};
      tbl[3]  = '{1'b1, 1'b0, 3'b011, 3'b010, 1'b1, 8'hB1};
      tbl[4]  = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 8'hC2};
      tbl[5]  = '{1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 8'h00};
      tbl[6]  = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00};
      tbl[8]  = '{1'b1, 1'b0, 3'b100, 3'b100, 1'b1, 8'hC2};
      tbl[9]  = '{1'b1, 1'b0, 3'b110, 3'b010, 1'b1, 8'hB1};
      tbl[10] = '{1'b1, 1'b0, 3'b101, 3'b100, 1'b1, 8'hC2};
      tbl[11] = '{1'b1, 1'b0, 3'b101, 3'b001, 1'b1, 8'hA0};
      tbl[12] = '{1'b1, 1'b0, 3'b101, 3'b100, 1'b1, 8'hC2};

      // Reset held three cycles with requests pending.
      en = 1'b1;
      req_valid = 3'b011;
      req_data = RRD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("rst_ready", 32'(req_ready), 0);
         checkOutput("rst_wr_en", 32'(fifo_wr_en), 0);
         checkOutput("rst_wdata", 32'(fifo_wdata), 0);
         checkOutput("rst_rd_en", 32'(fifo_rd_en), 0);
         checkOutput("rst_start", 32'(tx_start), 0);
         checkOutput("rst_tx_data", 32'(tx_data), 0);
         checkOutput("rst_count", 32'(tx_count), 0);
      end
      rst = 1'b0;
      req_valid = '0;
      base = sent_q.size();

      // Arbiter vector table.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i].e, tbl[i].v, RRD, tbl[i].f);
         checkOutput($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
         checkOutput($sformatf("rr%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].wr));
         checkOutput($sformatf("rr%0d_wdata", i), 32'(fifo_wdata), 32'(tbl[i].wd));
      end
      applyStimulus(1'b1, '0, '0, 1'b0);

      // Full fifo: writes blocked until one pop frees a slot.
      do_reset(2);
      busy_len = 10;
      busy_force = 1'b1;
      @(negedge clk);
      preload_req = 1'b1;
      @(negedge clk);
      preload_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'b001, {16'h0, 8'h5A}, 1'b0);
         checkOutput("full_ready", 32'(req_ready), 0);
         checkOutput("full_wr_en", 32'(fifo_wr_en), 0);
      end
      busy_force = 1'b0;
      k = 0;
      do begin
         step();
         checkOutput("full_wait_ready", 32'(req_ready), 0);
         k++;
      end while (!fifo_rd_en && k < 10);
      checkOutput("full_pop_seen", 32'(fifo_rd_en), 1);
      step();
      checkOutput("full_resume_ready", 32'(req_ready), 1);
      checkOutput("full_resume_wr_en", 32'(fifo_wr_en), 1);
      checkOutput("full_resume_wdata", 32'(fifo_wdata), 'h5A);
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h5A}, 1'b0);
      checkOutput("full_again_ready", 32'(req_ready), 0);
      checkOutput("full_level", fifo_cnt, DEPTH);
      applyStimulus(1'b1, '0, '0, 1'b0);

      // Drain two words through a 10-cycle transmitter.
      do_reset(2);
      busy_len = 10;
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h55}, 1'b0);
      checkOutput("drain_push0", 32'(fifo_wdata), 'h55);
      applyStimulus(1'b1, 3'b010, {8'h0, 8'hAA, 8'h0}, 1'b0);
      checkOutput("drain_push1_ready", 32'(req_ready), 2);
      checkOutput("drain_push1", 32'(fifo_wdata), 'hAA);
      applyStimulus(1'b1, '0, '0, 1'b0);
      wait_sent(2, 200, "drain_starts");
      checkOutput("drain_count", 32'(tx_count), 2);
      if (sent_q.size() - base >= 2) begin
         checkOutput("drain_word0", 32'(sent_q[base]), 'h55);
         checkOutput("drain_word1", 32'(sent_q[base+1]), 'hAA);
         checkOutput("drain_spacing_ge13", 32'((start_q[base+1] - start_q[base]) >= 13), 1);
      end

      // Disable during the first frame of three.
      do_reset(2);
      busy_len = 10;
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h11}, 1'b0);
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h22}, 1'b0);
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h33}, 1'b0);
      applyStimulus(1'b1, '0, '0, 1'b0);
      wait_sent(1, 50, "dis_first_start");
      en = 1'b0;
      rdn = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (fifo_rd_en) rdn++;
      end
      checkOutput("dis_no_pop", rdn, 0);
      checkOutput("dis_sent", sent_q.size() - base, 1);
      checkOutput("dis_tx_data", 32'(tx_data), 'h11);
      checkOutput("dis_count", 32'(tx_count), 1);
      en = 1'b1;
      wait_sent(3, 100, "dis_resume");
      if (sent_q.size() - base >= 3) begin
         checkOutput("dis_word1", 32'(sent_q[base+1]), 'h22);
         checkOutput("dis_word2", 32'(sent_q[base+2]), 'h33);
      end

      // Counter wrap after 17 words, then a reset in the middle of a frame.
      do_reset(2);
      busy_len = 3;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 3'b001, {16'h0, WIDTH'(i + 'h40)}, 1'b0);
      end
      applyStimulus(1'b1, '0, '0, 1'b0);
      wait_sent(17, 400, "wrap_starts");
      checkOutput("wrap_count", 32'(tx_count), 1);
      for (int i = 0; i < 17; i++) begin
         if (sent_q.size() - base > i) begin
            checkOutput($sformatf("wrap_word%0d", i), 32'(sent_q[base+i]), 32'(i + 'h40));
         end
      end
      busy_len = 10;
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h77}, 1'b0);
      applyStimulus(1'b1, '0, '0, 1'b0);
      wait_sent(18, 50, "midrst_start");
      repeat (4) step();
      @(negedge clk);
      rst = 1'b1;
      step();
      checkOutput("midrst_count", 32'(tx_count), 0);
      checkOutput("midrst_tx_data", 32'(tx_data), 0);
      checkOutput("midrst_start", 32'(tx_start), 0);
      checkOutput("midrst_rd_en", 32'(fifo_rd_en), 0);
      rst = 1'b0;
      base = sent_q.size();
      applyStimulus(1'b1, 3'b001, {16'h0, 8'h5C}, 1'b0);
      applyStimulus(1'b1, '0, '0, 1'b0);
      wait_sent(1, 8, "postrst_start");
      if (sent_q.size() - base >= 1) checkOutput("postrst_word", 32'(sent_q[base]), 'h5C);
      checkOutput("postrst_count", 32'(tx_count), 1);

      // Randomized traffic against the round-robin reference model.
      for (int phase = 0; phase < 2; phase++) begin
         do_reset(2);
         busy_len = (phase == 0) ? 0 : 5;
         mptr = 0;
         exp_q.delete();
         for (int c = 0; c < 400; c++) begin
            e = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            v = NREQ'($urandom);
            d = DW'($urandom);
            applyStimulus(e, v, d, f);
            er = '0;
            ew = 1'b0;
            ewd = '0;
            mcand = -1;
            if (e && !fifo_full) begin
               for (int j = 0; j < NREQ; j++) begin
                  if (mcand < 0 && v[(mptr + j) % NREQ]) mcand = (mptr + j) % NREQ;
               end
            end
            if (mcand >= 0) begin
               er[mcand] = 1'b1;
               ew = 1'b1;
               ewd = d[mcand*WIDTH +: WIDTH];
               exp_q.push_back(ewd);
               mptr = (mcand + 1) % NREQ;
            end
            checkOutput("rand_ready", 32'(req_ready), 32'(er));
            checkOutput("rand_wr_en", 32'(fifo_wr_en), 32'(ew));
            checkOutput("rand_wdata", 32'(fifo_wdata), 32'(ewd));
         end
         applyStimulus(1'b1, '0, '0, 1'b0);
         wait_sent(exp_q.size(), 6000, "rand_drain");
         for (int i = 0; i < exp_q.size(); i++) begin
            if (sent_q.size() - base > i) begin
               checkOutput("rand_word", 32'(sent_q[base+i]), 32'(exp_q[i]));
            end
         end
         checkOutput("rand_count", 32'(tx_count), exp_q.size() % (1 << CNTW));
      end

      checkOutput("fifo_overflow", overflow_n, 0);
      checkOutput("fifo_underflow", underflow_n, 0);
      checkOutput("rd_back_to_back", b2b_n, 0);
      checkOutput("tx_data_hold", hold_n, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
